// File: rtl/s_axi_lite_dpmem.sv
// Purpose: AXI4-Lite slave memory with a second, independent fabric-side port.
// Latency: AXI write response and read data 1 cycle after execution; usr_rdata 1 cycle after usr_en.
// Backpressure: one-entry skids on AW, W and AR; a stalled B or R channel fills the skids, then drops the readies.
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETn : clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*     : AXI4-Lite slave (PROT inputs are ignored)
//   usr_en/usr_we/usr_addr/usr_wdata/usr_rdata : fabric word port, full-word writes, read-first
//   coll_cnt / coll_clr        : saturating count of same-word AXI/user write collisions, sync clear
module s_axi_lite_dpmem #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10,
  parameter int MEM_DEPTH          = 128
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic                              usr_en,
  input  logic                              usr_we,
  input  logic [$clog2(MEM_DEPTH)-1:0]      usr_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     usr_wdata,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     usr_rdata,
  output logic [15:0]                       coll_cnt,
  input  logic                              coll_clr
);

  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int NB       = DW / 8;
  localparam int ADDR_LSB = $clog2(DW / 8);
  localparam int IW       = $clog2(MEM_DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] mem [MEM_DEPTH];

  // Skid registers
  logic          aw_full;
  logic [AW-1:0] aw_addr_q;
  logic          w_full;
  logic [DW-1:0] w_dat_q;
  logic [NB-1:0] w_strb_q;
  logic          ar_full;
  logic [AW-1:0] ar_addr_q;

  // Response registers
  logic          bvalid_q;
  logic [1:0]    bresp_q;
  logic          rvalid_q;
  logic [1:0]    rresp_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] usr_rdata_q;
  logic [15:0]   coll_cnt_q;

  // Write path: an address and data are each taken from the skid when held, else live.
  logic          aw_avail, w_avail, b_free, wr_go;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_dat;
  logic [NB-1:0] wr_strb;
  logic [IW-1:0] wr_idx;
  logic          wr_oor, usr_wr, coll, axi_wr_en;

  assign aw_avail  = aw_full | S_AXI_AWVALID;
  assign w_avail   = w_full  | S_AXI_WVALID;
  assign b_free    = ~bvalid_q | S_AXI_BREADY;
  assign wr_go     = aw_avail & w_avail & b_free;
  assign wr_addr   = aw_full ? aw_addr_q : S_AXI_AWADDR;
  assign wr_dat    = w_full  ? w_dat_q   : S_AXI_WDATA;
  assign wr_strb   = w_full  ? w_strb_q  : S_AXI_WSTRB;
  assign wr_idx    = wr_addr[IW+ADDR_LSB-1:ADDR_LSB];
  assign wr_oor    = (wr_addr >> (IW + ADDR_LSB)) != '0;
  assign usr_wr    = usr_en & usr_we;
  // Same-word collision: the user write owns the whole word, the AXI write is dropped silently.
  assign coll      = wr_go & ~wr_oor & usr_wr & (usr_addr == wr_idx);
  assign axi_wr_en = wr_go & ~wr_oor & ~coll;

  // Read path
  logic          ar_avail, r_free, rd_go;
  logic [AW-1:0] rd_addr;
  logic [IW-1:0] rd_idx;
  logic          rd_oor;

  assign ar_avail = ar_full | S_AXI_ARVALID;
  assign r_free   = ~rvalid_q | S_AXI_RREADY;
  assign rd_go    = ar_avail & r_free;
  assign rd_addr  = ar_full ? ar_addr_q : S_AXI_ARADDR;
  assign rd_idx   = rd_addr[IW+ADDR_LSB-1:ADDR_LSB];
  assign rd_oor   = (rd_addr >> (IW + ADDR_LSB)) != '0;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[ADDR_LSB-1:0], rd_addr[ADDR_LSB-1:0]};

  // Storage is never reset. Both ports may write in the same cycle; collisions are
  // excluded from axi_wr_en, so the two writes never target the same word.
  always_ff @(posedge S_AXI_ACLK) begin
    if (axi_wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_dat[8*b +: 8];
      end
    end
    if (usr_wr) mem[usr_addr] <= usr_wdata;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      aw_full   <= 1'b0;
      aw_addr_q <= '0;
      w_full    <= 1'b0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      // A skid only fills when its beat arrives but the write cannot execute this cycle.
      if (aw_full) begin
        if (wr_go) aw_full <= 1'b0;
      end else if (S_AXI_AWVALID && !wr_go) begin
        aw_full   <= 1'b1;
        aw_addr_q <= S_AXI_AWADDR;
      end

      if (w_full) begin
        if (wr_go) w_full <= 1'b0;
      end else if (S_AXI_WVALID && !wr_go) begin
        w_full   <= 1'b1;
        w_dat_q  <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end

      if (wr_go) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      ar_full   <= 1'b0;
      ar_addr_q <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      if (ar_full) begin
        if (rd_go) ar_full <= 1'b0;
      end else if (S_AXI_ARVALID && !rd_go) begin
        ar_full   <= 1'b1;
        ar_addr_q <= S_AXI_ARADDR;
      end

      // Array read sees pre-edge contents, so a same-cycle write to the word returns old data.
      if (rd_go) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rd_oor ? RESP_SLVERR : RESP_OKAY;
        rdata_q  <= rd_oor ? '0 : mem[rd_idx];
      end else if (S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETn) begin
    if (!S_AXI_ARESETn) begin
      usr_rdata_q <= '0;
      coll_cnt_q  <= '0;
    end else begin
      if (usr_en) usr_rdata_q <= mem[usr_addr];
      if (coll_clr) begin
        coll_cnt_q <= '0;
      end else if (coll && coll_cnt_q != 16'hFFFF) begin
        coll_cnt_q <= coll_cnt_q + 16'd1;
      end
    end
  end

  assign S_AXI_AWREADY = ~aw_full;
  assign S_AXI_WREADY  = ~w_full;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = ~ar_full;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign usr_rdata     = usr_rdata_q;
  assign coll_cnt      = coll_cnt_q;

endmodule

// File: tb/tb_s_axi_lite_dpmem.sv
// Purpose: directed bench for s_axi_lite_dpmem (32-bit data, 10-bit address, 128 words).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: BREADY/RREADY stalls applied in dedicated scenarios.
module tb_s_axi_lite_dpmem;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int DEPTH = 128;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESETn;
  logic [AW-1:0] S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID, S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY;
  logic [AW-1:0] S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic          usr_en, usr_we, coll_clr;
  logic [6:0]    usr_addr;
  logic [DW-1:0] usr_wdata, usr_rdata;
  logic [15:0]   coll_cnt;

  int vectors = 0;
  int errors  = 0;
  logic [DW-1:0] shadow [DEPTH];

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  s_axi_lite_dpmem dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETn(S_AXI_ARESETn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .usr_en(usr_en), .usr_we(usr_we), .usr_addr(usr_addr),
    .usr_wdata(usr_wdata), .usr_rdata(usr_rdata),
    .coll_cnt(coll_cnt), .coll_clr(coll_clr)
  );

  // Bus drivers (no checking here); all start and end on a falling edge.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int hs_cyc, output int lat);
    bit aw_done = 0, w_done = 0;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    hs_cyc = 0;
    while (!(aw_done && w_done) && hs_cyc < 20) begin
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      @(negedge S_AXI_ACLK); hs_cyc++;
      if (aw_done) S_AXI_AWVALID = 0;
      if (w_done) S_AXI_WVALID = 0;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    lat = 0;
    while (!S_AXI_BVALID && lat < 20) begin @(negedge S_AXI_ACLK); lat++; end
    resp = S_AXI_BVALID ? S_AXI_BRESP : 2'b11;
    @(negedge S_AXI_ACLK);
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    while (!S_AXI_ARREADY && n < 20) begin @(negedge S_AXI_ACLK); n++; end
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 0;
    lat = 0;
    while (!S_AXI_RVALID && lat < 20) begin @(negedge S_AXI_ACLK); lat++; end
    d = S_AXI_RVALID ? S_AXI_RDATA : 'x;
    resp = S_AXI_RVALID ? S_AXI_RRESP : 2'b11;
    @(negedge S_AXI_ACLK);
  endtask

  task automatic test_reset();
    logic [1:0] r; int h, l;
    @(negedge S_AXI_ACLK); @(negedge S_AXI_ACLK);
    vectors++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP} !== 9'b111_00_0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected %b", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP}, 9'b111_00_0000); end
    vectors++; if ({S_AXI_RDATA, usr_rdata, coll_cnt} !== 80'h0) begin
      errors++; $display("FAIL reset_data: rdata %h usr_rdata %h coll_cnt %h expected all zero", S_AXI_RDATA, usr_rdata, coll_cnt); end
    S_AXI_ARESETn = 1;
    axi_write(10'h000, 32'h0000_0001, 4'hF, r, h, l);
    vectors++; if (h !== 1) begin errors++; $display("FAIL reset_first_hs: handshake after %0d cycles expected 1", h); end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < DEPTH; i++) begin
      usr_en = 1; usr_we = 1; usr_addr = 7'(i);
      usr_wdata = {8'(i) ^ 8'hA5, 8'(i), ~8'(i), 8'h3C + 8'(i)};
      shadow[i] = usr_wdata;
      @(negedge S_AXI_ACLK);
    end
    usr_en = 0; usr_we = 0;
  endtask

  task automatic test_basic();
    logic [1:0] r; logic [DW-1:0] d; int h, l;
    axi_write(10'h004, 32'hDEAD_BEEF, 4'hF, r, h, l);
    shadow[1] = 32'hDEAD_BEEF;
    vectors++; if ({r, h[7:0], l[7:0]} !== {2'b00, 8'd1, 8'd0}) begin
      errors++; $display("FAIL basic_write: bresp %b hs %0d lat %0d expected 00/1/0", r, h, l); end
    axi_read(10'h004, d, r, l);
    vectors++; if ({d, r, l[7:0]} !== {32'hDEAD_BEEF, 2'b00, 8'd0}) begin
      errors++; $display("FAIL basic_read: rdata %h rresp %b lat %0d expected deadbeef/00/0", d, r, l); end
  endtask

  task automatic test_partial();
    logic [1:0] r; logic [DW-1:0] d; int h, l;
    axi_write(10'h008, 32'h1122_3344, 4'hF, r, h, l);
    S_AXI_AWADDR = 10'h008; S_AXI_AWVALID = 1; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if ({S_AXI_AWREADY, S_AXI_BVALID} !== 2'b00) begin
        errors++; $display("FAIL partial_aw_held%0d: awready/bvalid %b expected 00", k, {S_AXI_AWREADY, S_AXI_BVALID}); end
      if (k < 2) @(negedge S_AXI_ACLK);
    end
    S_AXI_WDATA = 32'h7766_AB55; S_AXI_WSTRB = 4'b0010; S_AXI_WVALID = 1;
    @(negedge S_AXI_ACLK);
    S_AXI_WVALID = 0;
    vectors++; if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY} !== 4'b1001) begin
      errors++; $display("FAIL partial_bresp: bvalid/bresp/awready %b expected 1001", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY}); end
    @(negedge S_AXI_ACLK);
    axi_read(10'h008, d, r, l);
    vectors++; if (d !== 32'h1122_AB44) begin errors++; $display("FAIL partial_readback: got %h expected 1122ab44", d); end
    axi_write(10'h008, 32'hFFFF_FFFF, 4'h0, r, h, l);
    vectors++; if (r !== 2'b00) begin errors++; $display("FAIL zero_strb_resp: got %b expected 00", r); end
    axi_read(10'h008, d, r, l);
    vectors++; if (d !== 32'h1122_AB44) begin errors++; $display("FAIL zero_strb_readback: got %h expected 1122ab44", d); end
    shadow[2] = 32'h1122_AB44;
  endtask

  task automatic test_out_of_range();
    logic [1:0] r; logic [DW-1:0] d; int h, l; int bad = 0;
    axi_read(10'h200, d, r, l);
    vectors++; if ({r, d} !== {2'b10, 32'h0}) begin errors++; $display("FAIL oor_read: rresp %b rdata %h expected 10/0", r, d); end
    axi_write(10'h200, 32'hFFFF_FFFF, 4'hF, r, h, l);
    vectors++; if (r !== 2'b10) begin errors++; $display("FAIL oor_write: bresp %b expected 10", r); end
    for (int i = 0; i < DEPTH; i++) begin
      axi_read(10'(i * 4), d, r, l);
      if (d !== shadow[i] || r !== 2'b00) bad++;
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL oor_mem_intact: %0d words differ expected 0", bad); end
  endtask

  task automatic test_b_stall();
    logic [1:0] r; logic [DW-1:0] d; int l; int bcnt = 0;
    S_AXI_AWADDR = 10'h010; S_AXI_WDATA = 32'hCAFE_0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    @(negedge S_AXI_ACLK);
    vectors++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b111) begin
      errors++; $display("FAIL bstall_first: bvalid/awready/wready %b expected 111", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
    S_AXI_AWADDR = 10'h014; S_AXI_WDATA = 32'hCAFE_0002;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100) begin
        errors++; $display("FAIL bstall_held%0d: bvalid/awready/wready %b expected 100", k, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
      @(negedge S_AXI_ACLK);
    end
    S_AXI_BREADY = 1;
    for (int k = 0; k < 4; k++) begin
      if (S_AXI_BVALID && S_AXI_BREADY && S_AXI_BRESP == 2'b00) bcnt++;
      @(negedge S_AXI_ACLK);
    end
    vectors++; if (bcnt !== 2) begin errors++; $display("FAIL bstall_bcount: %0d responses expected 2", bcnt); end
    vectors++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
      errors++; $display("FAIL bstall_drain: bvalid/awready/wready %b expected 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
    shadow[4] = 32'hCAFE_0001; shadow[5] = 32'hCAFE_0002;
    axi_read(10'h010, d, r, l);
    vectors++; if (d !== 32'hCAFE_0001) begin errors++; $display("FAIL bstall_word4: got %h expected cafe0001", d); end
    axi_read(10'h014, d, r, l);
    vectors++; if (d !== 32'hCAFE_0002) begin errors++; $display("FAIL bstall_word5: got %h expected cafe0002", d); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      S_AXI_AWADDR = 10'(32 + 4 * i); S_AXI_WDATA = 32'h1000_0000 + 32'(i) * 32'h0101;
      S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
      shadow[8 + i] = S_AXI_WDATA;
      vectors++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== {2'b11, i > 0}) begin
        errors++; $display("FAIL b2b_write%0d: awready/wready/bvalid %b expected %b", i, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, {2'b11, i > 0}); end
      @(negedge S_AXI_ACLK);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    vectors++; if (S_AXI_BVALID !== 1'b1) begin errors++; $display("FAIL b2b_last_b: bvalid %b expected 1", S_AXI_BVALID); end
    @(negedge S_AXI_ACLK);
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin S_AXI_ARADDR = 10'(32 + 4 * i); S_AXI_ARVALID = 1; end
      else S_AXI_ARVALID = 0;
      S_AXI_RREADY = 1;
      if (i > 0) begin
        vectors++; if ({S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RDATA} !== {2'b11, shadow[8 + i - 1]}) begin
          errors++; $display("FAIL b2b_read%0d: arready/rvalid %b rdata %h expected 11 %h", i - 1, {S_AXI_ARREADY, S_AXI_RVALID}, S_AXI_RDATA, shadow[8 + i - 1]); end
      end
      @(negedge S_AXI_ACLK);
    end
  endtask

  task automatic test_rw_same_word();
    logic [1:0] r; logic [DW-1:0] d; int l;
    logic [DW-1:0] old_val;
    old_val = shadow[40];
    S_AXI_AWADDR = 10'h0A0; S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 10'h0A0; S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    vectors++; if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA} !== {2'b11, old_val}) begin
      errors++; $display("FAIL rw_same_old: rvalid/bvalid %b rdata %h expected 11 %h", {S_AXI_RVALID, S_AXI_BVALID}, S_AXI_RDATA, old_val); end
    @(negedge S_AXI_ACLK);
    shadow[40] = 32'h0BAD_F00D;
    axi_read(10'h0A0, d, r, l);
    vectors++; if (d !== 32'h0BAD_F00D) begin errors++; $display("FAIL rw_same_new: got %h expected 0badf00d", d); end
  endtask

  // One cycle with an AXI write and a user write issued together.
  task automatic dual_write(input logic [AW-1:0] a, input logic [DW-1:0] ad,
                            input logic [6:0] ua, input logic [DW-1:0] ud, input logic clr);
    S_AXI_AWADDR = a; S_AXI_WDATA = ad; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
    usr_en = 1; usr_we = 1; usr_addr = ua; usr_wdata = ud; coll_clr = clr;
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; usr_en = 0; usr_we = 0; coll_clr = 0;
  endtask

  task automatic test_collision();
    logic [1:0] r; logic [DW-1:0] d; int l;
    dual_write(10'h00C, 32'hAAAA_AAAA, 7'd3, 32'h5555_5555, 1'b0);
    vectors++; if ({S_AXI_BVALID, S_AXI_BRESP, coll_cnt} !== {3'b100, 16'd1}) begin
      errors++; $display("FAIL coll_first: bvalid/bresp %b coll_cnt %0d expected 100/1", {S_AXI_BVALID, S_AXI_BRESP}, coll_cnt); end
    @(negedge S_AXI_ACLK);
    axi_read(10'h00C, d, r, l);
    vectors++; if (d !== 32'h5555_5555) begin errors++; $display("FAIL coll_word3: got %h expected 55555555", d); end
    coll_clr = 1; @(negedge S_AXI_ACLK); coll_clr = 0;
    vectors++; if (coll_cnt !== 16'd0) begin errors++; $display("FAIL coll_clear: coll_cnt %0d expected 0", coll_cnt); end
    dual_write(10'h018, 32'h6666_0006, 7'd7, 32'h7777_0007, 1'b0);
    @(negedge S_AXI_ACLK);
    vectors++; if (coll_cnt !== 16'd0) begin errors++; $display("FAIL coll_diff_word: coll_cnt %0d expected 0", coll_cnt); end
    axi_read(10'h018, d, r, l);
    vectors++; if (d !== 32'h6666_0006) begin errors++; $display("FAIL coll_diff_axi: got %h expected 66660006", d); end
    axi_read(10'h01C, d, r, l);
    vectors++; if (d !== 32'h7777_0007) begin errors++; $display("FAIL coll_diff_usr: got %h expected 77770007", d); end
    dual_write(10'h00C, 32'h1234_5678, 7'd3, 32'h8765_4321, 1'b1);
    vectors++; if (coll_cnt !== 16'd0) begin errors++; $display("FAIL coll_clr_priority: coll_cnt %0d expected 0", coll_cnt); end
    @(negedge S_AXI_ACLK);
    axi_read(10'h00C, d, r, l);
    vectors++; if (d !== 32'h8765_4321) begin errors++; $display("FAIL coll_word3_second: got %h expected 87654321", d); end
    shadow[3] = 32'h8765_4321; shadow[6] = 32'h6666_0006; shadow[7] = 32'h7777_0007;
  endtask

  task automatic test_usr_port();
    logic [DW-1:0] old_val;
    old_val = shadow[9];
    usr_en = 1; usr_we = 1; usr_addr = 7'd9; usr_wdata = 32'hFACE_0009;
    @(negedge S_AXI_ACLK);
    vectors++; if (usr_rdata !== old_val) begin errors++; $display("FAIL usr_read_first: got %h expected %h", usr_rdata, old_val); end
    usr_we = 0; shadow[9] = 32'hFACE_0009;
    @(negedge S_AXI_ACLK);
    vectors++; if (usr_rdata !== 32'hFACE_0009) begin errors++; $display("FAIL usr_read: got %h expected face0009", usr_rdata); end
    usr_en = 0; usr_addr = 7'd10;
    @(negedge S_AXI_ACLK);
    vectors++; if (usr_rdata !== 32'hFACE_0009) begin errors++; $display("FAIL usr_hold: got %h expected face0009", usr_rdata); end
  endtask

  task automatic test_reset_midread();
    logic [1:0] r; logic [DW-1:0] d; int l; int rseen = 0;
    S_AXI_ARADDR = 10'h004; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(negedge S_AXI_ACLK);
    S_AXI_ARADDR = 10'h008;
    vectors++; if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b11) begin
      errors++; $display("FAIL midrd_rvalid: rvalid/arready %b expected 11", {S_AXI_RVALID, S_AXI_ARREADY}); end
    @(negedge S_AXI_ACLK);
    S_AXI_ARVALID = 0;
    vectors++; if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b10) begin
      errors++; $display("FAIL midrd_held: rvalid/arready %b expected 10", {S_AXI_RVALID, S_AXI_ARREADY}); end
    #2 S_AXI_ARESETn = 0;
    #1;
    vectors++; if ({S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RRESP, S_AXI_RDATA} !== {2'b01, 2'b00, 32'h0}) begin
      errors++; $display("FAIL midrd_async: rvalid/arready %b rresp %b rdata %h expected 01/00/0", {S_AXI_RVALID, S_AXI_ARREADY}, S_AXI_RRESP, S_AXI_RDATA); end
    @(negedge S_AXI_ACLK);
    S_AXI_ARESETn = 1; S_AXI_RREADY = 1;
    for (int k = 0; k < 5; k++) begin
      if (S_AXI_RVALID) rseen++;
      @(negedge S_AXI_ACLK);
    end
    vectors++; if (rseen !== 0) begin errors++; $display("FAIL midrd_no_beat: %0d R beats expected 0", rseen); end
    axi_read(10'h00C, d, r, l);
    vectors++; if (d !== shadow[3]) begin errors++; $display("FAIL mem_survives_reset: got %h expected %h", d, shadow[3]); end
  endtask

  initial begin
    S_AXI_ARESETn = 0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    usr_en = 0; usr_we = 0; usr_addr = '0; usr_wdata = '0; coll_clr = 0;
    test_reset();
    fill_mem();
    test_basic();
    test_partial();
    test_out_of_range();
    test_b_stall();
    test_back_to_back();
    test_rw_same_word();
    test_collision();
    test_usr_port();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
